// File: rtl/sdram_init_sequencer.sv
`default_nettype none
// ============================================================================
// sdram_init_sequencer : SDRAM power-up wait, PRECHARGE-all, N AUTO REFRESH,
//                        LOAD MODE, then sticky init_done.  Rev 1.0
// ============================================================================
module sdram_init_sequencer #(
  parameter int          count_width    = 16,
  parameter int          powerup_cycles = 5000,
  parameter int          trp_cycles     = 2,
  parameter int          trfc_cycles    = 7,
  parameter int          tmrd_cycles    = 2,
  parameter int          init_refreshes = 2,
  parameter logic [12:0] mode_word      = 13'h020
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [count_width-1:0] timer_count,
  output logic                   timer_clear,
  output logic                   cke,
  output logic                   cs_n,
  output logic                   ras_n,
  output logic                   cas_n,
  output logic                   we_n,
  output logic [12:0]            addr,
  output logic [1:0]             ba,
  output logic                   init_done
);

  localparam logic [count_width-1:0] c_powerup_thr = count_width'(powerup_cycles - 1);
  localparam logic [count_width-1:0] c_trp_thr     = count_width'(trp_cycles - 2);
  localparam logic [count_width-1:0] c_trfc_thr    = count_width'(trfc_cycles - 2);
  localparam logic [count_width-1:0] c_tmrd_thr    = count_width'(tmrd_cycles - 2);
  localparam logic [3:0]             c_refreshes   = 4'(init_refreshes);

  localparam logic [3:0] c_cmd_nop      = 4'b0111;
  localparam logic [3:0] c_cmd_deselect = 4'b1111;
  localparam logic [3:0] c_cmd_pre      = 4'b0010;
  localparam logic [3:0] c_cmd_ref      = 4'b0001;
  localparam logic [3:0] c_cmd_lmr      = 4'b0000;

  typedef enum logic [2:0] {
    S_POWERUP_WAIT = 3'd0,
    S_PRECHARGE    = 3'd1,
    S_WAIT_TRP     = 3'd2,
    S_REFRESH      = 3'd3,
    S_WAIT_TRFC    = 3'd4,
    S_LOAD_MODE    = 3'd5,
    S_WAIT_TMRD    = 3'd6,
    S_DONE         = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        powerup_ok_q, powerup_ok_d;
  logic [3:0]  ref_cnt_q, ref_cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        cke_q, cke_d;
  logic        done_q, done_d;
  logic        clear_q, clear_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_POWERUP_WAIT;
      powerup_ok_q <= 1'b0;
      ref_cnt_q    <= 4'd0;
      cmd_q        <= c_cmd_deselect;
      addr_q       <= 13'd0;
      ba_q         <= 2'd0;
      cke_q        <= 1'b0;
      done_q       <= 1'b0;
      clear_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      powerup_ok_q <= powerup_ok_d;
      ref_cnt_q    <= ref_cnt_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      ba_q         <= ba_d;
      cke_q        <= cke_d;
      done_q       <= done_d;
      clear_q      <= clear_d;
    end
  end

  // The power-up compare is registered, giving the extra clock of margin so
  // PRECHARGE lands powerup_cycles+1 clocks after release. Command states
  // never look at timer_count: it is stale until the clear pulse takes effect.
  always_comb begin
    state_d      = state_q;
    powerup_ok_d = (timer_count >= c_powerup_thr);
    case (state_q)
      S_POWERUP_WAIT: if (powerup_ok_q) state_d = S_PRECHARGE;
      S_PRECHARGE:    state_d = S_WAIT_TRP;
      S_WAIT_TRP:     if (timer_count >= c_trp_thr) state_d = S_REFRESH;
      S_REFRESH:      state_d = S_WAIT_TRFC;
      S_WAIT_TRFC: begin
        if (timer_count >= c_trfc_thr) begin
          state_d = (ref_cnt_q < c_refreshes) ? S_REFRESH : S_LOAD_MODE;
        end
      end
      S_LOAD_MODE:    state_d = S_WAIT_TMRD;
      S_WAIT_TMRD:    if (timer_count >= c_tmrd_thr) state_d = S_DONE;
      S_DONE:         state_d = S_DONE;
      default:        state_d = S_POWERUP_WAIT;
    endcase
  end

  // Pins are decoded from the next state so a command, its timer clear and
  // the state that issues it all change on the same edge.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    cmd_d     = c_cmd_nop;
    addr_d    = 13'd0;
    ba_d      = 2'd0;
    cke_d     = 1'b1;
    done_d    = 1'b0;
    clear_d   = 1'b0;
    case (state_d)
      S_PRECHARGE: begin
        cmd_d     = c_cmd_pre;
        addr_d    = 13'h0400;
        clear_d   = 1'b1;
        ref_cnt_d = 4'd0;
      end
      S_REFRESH: begin
        cmd_d     = c_cmd_ref;
        clear_d   = 1'b1;
        ref_cnt_d = ref_cnt_q + 4'd1;
      end
      S_LOAD_MODE: begin
        cmd_d   = c_cmd_lmr;
        addr_d  = mode_word;
        clear_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign cs_n        = cmd_q[3];
  assign ras_n       = cmd_q[2];
  assign cas_n       = cmd_q[1];
  assign we_n        = cmd_q[0];
  assign addr        = addr_q;
  assign ba          = ba_q;
  assign cke         = cke_q;
  assign init_done   = done_q;
  assign timer_clear = clear_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sdram_init_sequencer : three sequencer configurations driven by
//                           behavioural saturating timers.  Rev 1.0
// ============================================================================
module tb_sdram_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  int checks = 0;
  int failures = 0;

  // dut0: defaults, dut1: 4 refreshes / trfc 3, dut2: 4-bit saturating timer
  int cfg_p    [3] = '{5000, 5000, 15};
  int cfg_trp  [3] = '{2, 2, 2};
  int cfg_trfc [3] = '{7, 3, 2};
  int cfg_tmrd [3] = '{2, 2, 2};
  int cfg_n    [3] = '{2, 4, 2};

  localparam logic [21:0] RST_VEC = {1'b0, 4'b1111, 13'h0, 2'b0, 1'b0, 1'b1};

  logic        clr [3], cke [3], cs_n [3], ras_n [3], cas_n [3], we_n [3], done [3];
  logic [12:0] addr [3];
  logic [1:0]  ba [3];
  logic [15:0] cnt0 = '0, cnt1 = '0;
  logic [3:0]  cnt2 = '0;

  always @(posedge clk) begin
    cnt0 <= clr[0] ? 16'd0 : ((cnt0 == 16'hFFFF) ? cnt0 : cnt0 + 16'd1);
    cnt1 <= clr[1] ? 16'd0 : ((cnt1 == 16'hFFFF) ? cnt1 : cnt1 + 16'd1);
    cnt2 <= clr[2] ? 4'd0  : ((cnt2 == 4'hF)     ? cnt2 : cnt2 + 4'd1);
  end

  sdram_init_sequencer u_dut0 (
    .clk(clk), .reset_n(reset_n), .timer_count(cnt0), .timer_clear(clr[0]),
    .cke(cke[0]), .cs_n(cs_n[0]), .ras_n(ras_n[0]), .cas_n(cas_n[0]), .we_n(we_n[0]),
    .addr(addr[0]), .ba(ba[0]), .init_done(done[0]));

  sdram_init_sequencer #(.init_refreshes(4), .trfc_cycles(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .timer_count(cnt1), .timer_clear(clr[1]),
    .cke(cke[1]), .cs_n(cs_n[1]), .ras_n(ras_n[1]), .cas_n(cas_n[1]), .we_n(we_n[1]),
    .addr(addr[1]), .ba(ba[1]), .init_done(done[1]));

  sdram_init_sequencer #(.count_width(4), .powerup_cycles(15), .trp_cycles(2),
                         .trfc_cycles(2), .tmrd_cycles(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .timer_count(cnt2), .timer_clear(clr[2]),
    .cke(cke[2]), .cs_n(cs_n[2]), .ras_n(ras_n[2]), .cas_n(cas_n[2]), .we_n(we_n[2]),
    .addr(addr[2]), .ba(ba[2]), .init_done(done[2]));

  function automatic logic [21:0] act_vec(input int k);
    return {cke[k], cs_n[k], ras_n[k], cas_n[k], we_n[k], addr[k], ba[k], done[k], clr[k]};
  endfunction

  function automatic int t_pre(input int k);
    return cfg_p[k] + 1;
  endfunction
  function automatic int t_lmr(input int k);
    return t_pre(k) + cfg_trp[k] + cfg_n[k] * cfg_trfc[k];
  endfunction
  function automatic int t_done(input int k);
    return t_lmr(k) + cfg_tmrd[k];
  endfunction

  // Expected pins at clock c after release, from the command schedule.
  function automatic logic [21:0] exp_vec(input int k, input int c);
    logic [21:0] v;
    int r0;
    r0 = t_pre(k) + cfg_trp[k];
    v  = {1'b1, 4'b0111, 13'h0, 2'b0, 1'b0, 1'b0};
    if (c >= t_done(k))
      v[1] = 1'b1;
    else if (c == t_pre(k))
      v = {1'b1, 4'b0010, 13'h400, 2'b0, 1'b0, 1'b1};
    else if (c == t_lmr(k))
      v = {1'b1, 4'b0000, 13'h020, 2'b0, 1'b0, 1'b1};
    else if (c >= r0 && c < t_lmr(k) && ((c - r0) % cfg_trfc[k]) == 0)
      v = {1'b1, 4'b0001, 13'h0, 2'b0, 1'b0, 1'b1};
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  int          mism [3], first_bad [3], nref [3], nclr [3], pre_at [3], lmr_at [3], done_at [3];
  logic [21:0] bad_act [3], bad_exp [3];

  task automatic run_pass(input int ncyc, input bit full);
    logic [21:0] a, e;
    for (int k = 0; k < 3; k++) begin
      mism[k] = 0; first_bad[k] = -1; nref[k] = 0; nclr[k] = 0;
      pre_at[k] = -1; lmr_at[k] = -1; done_at[k] = -1;
      bad_act[k] = '0; bad_exp[k] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        a = act_vec(k);
        e = exp_vec(k, c);
        if (a !== e) begin
          if (mism[k] == 0) begin
            first_bad[k] = c; bad_act[k] = a; bad_exp[k] = e;
          end
          mism[k]++;
        end
        case (a[20:17])
          4'b0010: pre_at[k] = c;
          4'b0001: nref[k]++;
          4'b0000: lmr_at[k] = c;
          default: ;
        endcase
        if (a[1] && done_at[k] < 0) done_at[k] = c;
        if (a[0]) nclr[k]++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_trace first_bad_cycle=%0d pins=%h want=%h", k, first_bad[k],
                    bad_act[k], bad_exp[k]), mism[k], 0);
      if (full) begin
        chk($sformatf("dut%0d_precharge_cycle", k), pre_at[k], t_pre(k));
        chk($sformatf("dut%0d_refresh_count", k), nref[k], cfg_n[k]);
        chk($sformatf("dut%0d_load_mode_cycle", k), lmr_at[k], t_lmr(k));
        chk($sformatf("dut%0d_init_done_cycle", k), done_at[k], t_done(k));
        chk($sformatf("dut%0d_clear_pulses", k), nclr[k], 2 + cfg_n[k]);
      end
    end
  endtask

  // Assert reset asynchronously mid-cycle, hold for 'hold' edges, release on a falling edge.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #($urandom_range(1, 3));
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d_async_reset", k), int'(act_vec(k)), int'(RST_VEC));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("dut0_reset_hold", int'(act_vec(0)), int'(RST_VEC));
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    n = 5 + int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk($sformatf("dut%0d_reset_value", k), int'(act_vec(k)), int'(RST_VEC));
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_pass(t_done(0) + 1000, 1'b1);

    do_reset(1 + int'($urandom_range(0, 2)));
    n = int'($urandom_range(t_pre(0) + cfg_trp[0] + 1, t_pre(0) + cfg_trp[0] + cfg_trfc[0] - 1));
    run_pass(n, 1'b0);
    chk("dut0_refreshes_before_mid_reset", nref[0], 1);
    do_reset(1);
    run_pass(t_done(0) + 1000, 1'b1);

    n = int'($urandom_range(t_pre(2) + 1, t_done(2) - 1));
    do_reset(1 + int'($urandom_range(0, 2)));
    run_pass(n, 1'b0);
    do_reset(1);
    run_pass(t_done(0) + 1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/sdram_init_sequencer.md
# sdram_init_sequencer

Power-up initialisation sequencer for the SDRAM controller. It drives the shared saturating delay timer through `timer_clear` and reads the timer's `timer_count` back. Once the timer shows the required delay, it issues the JEDEC init sequence on the SDRAM command pins: precharge-all, N auto-refreshes, then load-mode-register. It then raises `init_done` so the main command scheduler can take over the pins.

## Interface
- `count_width`, 16: width of `timer_count`. The timer instance saturates at 2^count_width-1, which must be ≥ every delay below.
- `powerup_cycles`, 5000: minimum clocks from reset deassertion to PRECHARGE (200 µs at 25 MHz).
- `trp_cycles`, 2: PRECHARGE-to-next-command spacing.
- `trfc_cycles`, 7: AUTO REFRESH-to-next-command spacing.
- `tmrd_cycles`, 2: LOAD MODE-to-`init_done` spacing.
- `init_refreshes`, 2: number of AUTO REFRESH commands, 1..15.
- `mode_word`, 13'h020: value driven on `addr` during LOAD MODE (CAS 2, burst 1, sequential).
- All `*_cycles` parameters must be ≥ 2.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `timer_count`  in  count_width  current value of the saturating delay timer.
- `timer_clear`  out  1  synchronous active-high clear to the timer.
- `cke`  out  1  SDRAM clock enable.
- `cs_n`, `ras_n`, `cas_n`, `we_n`  out  1 each  SDRAM command.
- `addr`  out  13  SDRAM address.
- `ba`  out  2  SDRAM bank address.
- `init_done`  out  1  sequence complete, sticky until reset.

## Operation
- **Reset values:** `cke`=0, `cs_n`=`ras_n`=`cas_n`=`we_n`=1 (deselect), `addr`=0, `ba`=0, `init_done`=0, `timer_clear`=1.
- **Outputs:** all registered. Each command occupies the pins for exactly one clock.
- **NOP:** `cs_n`=0, `ras_n`=`cas_n`=`we_n`=1, `addr`=0, `ba`=0.
- **Commands ({cs_n,ras_n,cas_n,we_n}):**
  - PRECHARGE = 0010, with `addr[10]`=1 (all banks).
  - AUTO REFRESH = 0001.
  - LOAD MODE = 0000, with `addr`=`mode_word` and `ba`=0.
- **States:** POWERUP_WAIT → PRECHARGE → WAIT_TRP → REFRESH → WAIT_TRFC → (REFRESH again while refreshes issued < `init_refreshes`, else LOAD_MODE) → WAIT_TMRD → DONE.
- **POWERUP_WAIT:**
  - Entered on the first clock after reset release.
  - `cke` registers to 1 on that clock; pins carry NOP.
  - Leaves when `timer_count` ≥ `powerup_cycles`-1.
- **Command states (PRECHARGE, REFRESH, LOAD_MODE):**
  - Last exactly one cycle.
  - Pulse `timer_clear`=1 in the same cycle as the command appears on the pins.
  - REFRESH increments a 4-bit refresh counter, which is cleared in PRECHARGE.
- **Wait states:** exit when `timer_count` ≥ t-2, where t is the relevant `*_cycles`. The next command then lands exactly t clocks after the previous one. Pins carry NOP.
- **Comparisons:** zero-extend the parameters to `count_width`. The timer saturates, so use ≥, never ==.
- **DONE:**
  - `init_done`=1, `cke`=1, pins carry NOP, `timer_clear`=0.
  - Terminal; only reset leaves it.
- **Reset mid-sequence:** all outputs return to reset values immediately (asynchronously), and the sequence restarts from POWERUP_WAIT with the full power-up delay.

## Timing
- **Cycle 0:** first rising edge with `reset_n` high. `timer_clear` falls to 0 and `cke` rises to 1; the timer has been held at 0.
- **Power-up delay:** PRECHARGE appears on the pins powerup_cycles+1 clocks after cycle 0 (powerup_cycles-1 to saturate the comparison, plus 2 registered-state latency). It never appears earlier than `powerup_cycles`.
- **Command spacing:**
  - PRECHARGE→REFRESH = `trp_cycles` clocks.
  - REFRESH→REFRESH = `trfc_cycles`.
  - last REFRESH→LOAD MODE = `trfc_cycles`.
  - LOAD MODE→`init_done` high = `tmrd_cycles`.
- **Total with defaults:** `init_done` rises 5001+2+7+7+2 = 5019 clocks after cycle 0.
- **`timer_clear` pulses:** exactly 2+`init_refreshes` one-cycle pulses after cycle 0.

## Test plan
- **Reset values:** hold `reset_n`=0 for 5 clocks → `cke`=0, `cs_n`=1, `timer_clear`=1, `init_done`=0 throughout; outputs change asynchronously on assertion.
- **Full sequence, defaults:** with a behavioural saturating timer → command trace NOP…, PRECHARGE (`addr[10]`=1) at cycle 5001, REFRESH at 5003 and 5010, LOAD MODE (`addr`=13'h020, `ba`=0) at 5017, `init_done` at 5019.
- **Refresh count:** `init_refreshes`=4, `trfc_cycles`=3 → exactly 4 REFRESH commands, 3 clocks apart; LOAD MODE 3 clocks after the last one.
- **Saturation:** `count_width`=4, all delays=2, `powerup_cycles`=15, timer saturating at 15 → the sequence still completes; no hang on a held value.
- **Mid-sequence reset:** pulse `reset_n` low for 1 clock between the two REFRESH commands → pins deselect immediately, and a full power-up wait precedes a fresh PRECHARGE.
- **Spacing check:** a scoreboard asserts no non-NOP command within the required t of its predecessor, and that `init_done` stays 1 for 1000 clocks with NOPs only.
